// File: rtl/mem_io_responder_pkg.sv
// rtl/mem_io_responder_pkg.sv - shared constants for the memory/IO responder
// Contents: IO window tag, IO register offsets, status register bit indices.
package mem_io_responder_pkg;

  // addr[17:16] value that selects the IO window instead of RAM
  localparam logic [1:0] IO_WINDOW = 2'b11;

  // IO register offsets (addr[3:0])
  localparam logic [3:0] IO_DATA    = 4'h0;
  localparam logic [3:0] IO_STATUS  = 4'h4;
  localparam logic [3:0] IO_PERF_RD = 4'h8;
  localparam logic [3:0] IO_PERF_WR = 4'hC;

  // Status register bit positions
  localparam int STATUS_TX_FULL     = 0;
  localparam int STATUS_RX_NONEMPTY = 1;

endpackage

// File: rtl/mem_io_responder_fifo.sv
// rtl/mem_io_responder_fifo.sv - byte-wide synchronous FIFO used for TX and RX
// Ports:
//   clkIn, resetIn       clock, synchronous active-high reset (empties FIFO)
//   pushValid, pushData  push request and byte
//   popReq               pop request (ignored while empty)
//   headData             byte at the head (stale while empty)
//   notEmpty, full       occupancy flags
//   pushDropped          push request rejected because FIFO was full
module byte_fifo #(
  parameter int FIFO_WIDTH = 4
) (
  input  logic       clkIn,
  input  logic       resetIn,
  input  logic       pushValid,
  input  logic [7:0] pushData,
  input  logic       popReq,
  output logic [7:0] headData,
  output logic       notEmpty,
  output logic       full,
  output logic       pushDropped
);

  localparam int DEPTH = 1 << FIFO_WIDTH;

  logic [7:0]          mem [DEPTH];
  logic [FIFO_WIDTH:0] wrPtr;
  logic [FIFO_WIDTH:0] rdPtr;
  logic                doPush;
  logic                doPop;

  // Extra pointer MSB separates full (MSBs differ) from empty (all equal).
  assign notEmpty = (wrPtr != rdPtr);
  assign full     = (wrPtr[FIFO_WIDTH] != rdPtr[FIFO_WIDTH]) &&
                    (wrPtr[FIFO_WIDTH-1:0] == rdPtr[FIFO_WIDTH-1:0]);

  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign doPop       = popReq && notEmpty;
  assign doPush      = pushValid && (!full || doPop);
  assign pushDropped = pushValid && !doPush;
  assign headData    = mem[rdPtr[FIFO_WIDTH-1:0]];

  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clkIn) begin
    if (doPush) mem[wrPtr[FIFO_WIDTH-1:0]] <= pushData;
  end

endmodule

// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - byte-wide RAM plus IO window responder for the cache controller bus
// Ports:
//   clkIn, resetIn                 clock, synchronous active-high reset
//   memAddrIn, memWriteIn          bus address and direction (1 = write)
//   memDataIn, memDataOut          write byte in, registered read byte out (1-cycle latency)
//   txValidOut, txDataOut, txReadyIn   TX FIFO to host
//   rxValidIn, rxDataIn, rxReadyOut    RX FIFO from host
//   haltOut, txOverflowOut         sticky halt and TX-drop flags
// Optional: MEM_IO_PERF_EN adds RAM read/write counters at IO offsets 0x8-0xF.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_WIDTH = 4
) (
  input  logic        clkIn,
  input  logic        resetIn,
  input  logic [31:0] memAddrIn,
  input  logic        memWriteIn,
  input  logic [7:0]  memDataIn,
  output logic [7:0]  memDataOut,
  output logic        txValidOut,
  output logic [7:0]  txDataOut,
  input  logic        txReadyIn,
  input  logic        rxValidIn,
  input  logic [7:0]  rxDataIn,
  output logic        rxReadyOut,
  output logic        haltOut,
  output logic        txOverflowOut
);

  logic [7:0]  ram [1 << ADDR_WIDTH];

  logic        isIo;
  logic [3:0]  offset;
  logic        ramWrite;
  logic        ioWrite;
  logic        dataRead;
  logic        inRun;
  logic        runActive;
  logic [31:0] prevAddr;
  logic [7:0]  readByte;
  logic [7:0]  statusByte;

  logic        txPush;
  logic        txFull;
  logic        txDropped;
  logic [7:0]  txHead;
  logic        rxPop;
  logic        rxFull;
  logic        rxNotEmpty;
  logic [7:0]  rxHead;
  logic        rxUnusedDrop;

  assign isIo     = (memAddrIn[17:16] == IO_WINDOW);
  assign offset   = memAddrIn[3:0];
  assign ramWrite = memWriteIn && !isIo;
  assign ioWrite  = memWriteIn && isIo;
  assign dataRead = !memWriteIn && isIo && (offset == IO_DATA);

  // Repeated reads of the RX data register at an unchanged address are one
  // access: only the first cycle pops, later cycles keep returning that byte.
  assign inRun = dataRead && runActive && (memAddrIn == prevAddr);
  assign rxPop = dataRead && !inRun;

  assign txPush     = ioWrite && (offset == IO_DATA);
  assign rxReadyOut = !rxFull;
  assign txDataOut  = txValidOut ? txHead : 8'h00;

  byte_fifo #(.FIFO_WIDTH(FIFO_WIDTH)) txFifo (
    .clkIn       (clkIn),
    .resetIn     (resetIn),
    .pushValid   (txPush),
    .pushData    (memDataIn),
    .popReq      (txReadyIn),
    .headData    (txHead),
    .notEmpty    (txValidOut),
    .full        (txFull),
    .pushDropped (txDropped)
  );

  byte_fifo #(.FIFO_WIDTH(FIFO_WIDTH)) rxFifo (
    .clkIn       (clkIn),
    .resetIn     (resetIn),
    .pushValid   (rxValidIn && rxReadyOut),
    .pushData    (rxDataIn),
    .popReq      (rxPop),
    .headData    (rxHead),
    .notEmpty    (rxNotEmpty),
    .full        (rxFull),
    .pushDropped (rxUnusedDrop)
  );

`ifdef MEM_IO_PERF_EN
  logic [31:0] rdCount;
  logic [31:0] wrCount;

  always_ff @(posedge clkIn) begin
    if (resetIn || (ioWrite && offset == IO_PERF_RD)) begin
      rdCount <= '0;
      wrCount <= '0;
    end else begin
      if (!memWriteIn && !isIo && rdCount != 32'hFFFF_FFFF) rdCount <= rdCount + 32'd1;
      if (ramWrite && wrCount != 32'hFFFF_FFFF)             wrCount <= wrCount + 32'd1;
    end
  end
`endif

  always_comb begin
    statusByte                     = 8'h00;
    statusByte[STATUS_TX_FULL]     = txFull;
    statusByte[STATUS_RX_NONEMPTY] = rxNotEmpty;
  end

  always_comb begin
    readByte = 8'h00;
    if (!isIo) begin
      readByte = ram[memAddrIn[ADDR_WIDTH-1:0]];
    end else if (offset == IO_DATA) begin
      readByte = rxNotEmpty ? rxHead : 8'h00;
    end else if (offset == IO_STATUS) begin
      readByte = statusByte;
    end
`ifdef MEM_IO_PERF_EN
    // Little-endian byte lanes: 0x8-0xB rdCount, 0xC-0xF wrCount
    else if (offset[3]) begin
      readByte = offset[2] ? wrCount[{offset[1:0], 3'b000} +: 8]
                           : rdCount[{offset[1:0], 3'b000} +: 8];
    end
`endif
  end

  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      memDataOut    <= 8'h00;
      runActive     <= 1'b0;
      prevAddr      <= '0;
      haltOut       <= 1'b0;
      txOverflowOut <= 1'b0;
    end else begin
      runActive <= dataRead;
      prevAddr  <= memAddrIn;
      // Write cycles and continuing RX runs hold the last returned byte.
      if (!memWriteIn && !inRun) memDataOut <= readByte;
      if (ioWrite && offset == IO_STATUS) haltOut <= 1'b1;
      if (txDropped) txOverflowOut <= 1'b1;
    end
  end

  always_ff @(posedge clkIn) begin
    if (ramWrite) ram[memAddrIn[ADDR_WIDTH-1:0]] <= memDataIn;
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - self-checking bench for mem_io_responder
module tb_mem_io_responder;

  localparam logic [31:0] IO_BASE = 32'h0003_0000;
  localparam logic [31:0] IDLE    = 32'h0003_0004;

  logic        clkIn = 1'b0;
  logic        resetIn;
  logic [31:0] memAddrIn;
  logic        memWriteIn;
  logic [7:0]  memDataIn;
  logic [7:0]  memDataOut;
  logic        txValidOut;
  logic [7:0]  txDataOut;
  logic        txReadyIn;
  logic        rxValidIn;
  logic [7:0]  rxDataIn;
  logic        rxReadyOut;
  logic        haltOut;
  logic        txOverflowOut;

  always #5 clkIn = ~clkIn;

  mem_io_responder dut (
    .clkIn         (clkIn),
    .resetIn       (resetIn),
    .memAddrIn     (memAddrIn),
    .memWriteIn    (memWriteIn),
    .memDataIn     (memDataIn),
    .memDataOut    (memDataOut),
    .txValidOut    (txValidOut),
    .txDataOut     (txDataOut),
    .txReadyIn     (txReadyIn),
    .rxValidIn     (rxValidIn),
    .rxDataIn      (rxDataIn),
    .rxReadyOut    (rxReadyOut),
    .haltOut       (haltOut),
    .txOverflowOut (txOverflowOut)
  );

  int checksTotal  = 0;
  int checksPassed = 0;
  int checksFailed = 0;

  logic [7:0] ramModel [int];
  int         writtenAddrs[$];
  logic [7:0] txQ[$];
  logic [7:0] rxQ[$];
  logic [7:0] lastRead = 8'h00;
  logic [7:0] b;
  logic [7:0] expByte;
  int         addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checksTotal++;
    assert (obs === exp) checksPassed++;
    else begin
      checksFailed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkIn);
    #1;
  endtask

  task automatic busRead(input logic [31:0] a);
    memAddrIn  = a;
    memWriteIn = 1'b0;
    tick();
    memAddrIn  = IDLE;
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [7:0] d);
    memAddrIn  = a;
    memWriteIn = 1'b1;
    memDataIn  = d;
    tick();
    memWriteIn = 1'b0;
    memAddrIn  = IDLE;
  endtask

  task automatic ramWrite(input int a, input logic [7:0] d);
    busWrite(a, d);
    ramModel[a] = d;
    writtenAddrs.push_back(a);
    check("write_hold", memDataOut, lastRead);
  endtask

  task automatic ramRead(input int a);
    busRead(a);
    lastRead = ramModel[a];
    check("ram_read", memDataOut, lastRead);
  endtask

  initial begin
    resetIn = 1'b1; memAddrIn = IDLE; memWriteIn = 1'b0; memDataIn = 8'h00;
    txReadyIn = 1'b0; rxValidIn = 1'b0; rxDataIn = 8'h00;
    tick(); tick();
    check("rst_data", memDataOut, 8'h00);
    check("rst_txvalid", txValidOut, 1'b0);
    check("rst_rxready", rxReadyOut, 1'b1);
    check("rst_halt", haltOut, 1'b0);
    check("rst_ovf", txOverflowOut, 1'b0);
    resetIn = 1'b0;

    // RAM byte path, streaming reads, random traffic
    ramWrite(32'h10, 8'hA5);
    ramRead(32'h10);
    check("ram_a5", memDataOut, 8'hA5);
    for (int i = 0; i < 16; i++) ramWrite(i, 8'($urandom));
    for (int i = 0; i < 16; i++) ramRead(i);
    repeat (40) begin
      if ($urandom_range(0, 1) == 1) ramWrite(int'($urandom_range(0, 32'h1FFFF)), 8'($urandom));
      else ramRead(writtenAddrs[$urandom_range(0, writtenAddrs.size() - 1)]);
    end

    // TX basic path
    busWrite(IO_BASE, 8'h48);
    check("tx_valid_rise", txValidOut, 1'b1);
    busWrite(IO_BASE, 8'h69);
    check("tx_head_h", txDataOut, 8'h48);
    txReadyIn = 1'b1;
    tick();
    check("tx_head_i", txDataOut, 8'h69);
    tick();
    check("tx_drained", txValidOut, 1'b0);
    // push+pop on empty: push kept, pop ignored
    busWrite(IO_BASE, 8'h3C);
    check("tx_emptypp_valid", txValidOut, 1'b1);
    check("tx_emptypp_data", txDataOut, 8'h3C);
    tick();
    check("tx_emptypp_pop", txValidOut, 1'b0);
    txReadyIn = 1'b0;

    // TX fill, full push+pop, overflow, drain
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      busWrite(IO_BASE, b);
      txQ.push_back(b);
    end
    check("tx_full_noovf", txOverflowOut, 1'b0);
    rxValidIn = 1'b1; rxDataIn = 8'h77;
    tick();
    rxValidIn = 1'b0;
    rxQ.push_back(8'h77);
    busRead(IDLE);
    check("status_03", memDataOut, 8'h03);
    b = 8'($urandom);
    txReadyIn = 1'b1;
    busWrite(IO_BASE, b);
    txReadyIn = 1'b0;
    void'(txQ.pop_front());
    txQ.push_back(b);
    check("tx_fullpp_noovf", txOverflowOut, 1'b0);
    busRead(IDLE);
    check("tx_fullpp_still_full", memDataOut, 8'h03);
    busWrite(IO_BASE, 8'($urandom));
    check("tx_overflow", txOverflowOut, 1'b1);
    txReadyIn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      expByte = txQ.pop_front();
      check("tx_drain_valid", txValidOut, 1'b1);
      check("tx_drain_data", txDataOut, expByte);
      tick();
    end
    txReadyIn = 1'b0;
    check("tx_drain_empty", txValidOut, 1'b0);
    check("tx_ovf_sticky", txOverflowOut, 1'b1);

    // RX pop-once
    busRead(IO_BASE);
    check("rx_pop_77", memDataOut, rxQ.pop_front());
    rxValidIn = 1'b1; rxDataIn = 8'h11; tick();
    rxDataIn = 8'h22; tick();
    rxValidIn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      busRead(IO_BASE);
      check("rx_hold_11", memDataOut, 8'h11);
    end
    busRead(IDLE);
    check("rx_status_one_pop", memDataOut, 8'h02);
    busRead(IO_BASE);
    check("rx_22", memDataOut, 8'h22);
    busRead(IDLE);
    check("rx_status_empty", memDataOut, 8'h00);
    busRead(IO_BASE);
    check("rx_empty_00", memDataOut, 8'h00);
    busRead(IDLE);
    rxValidIn = 1'b1; rxDataIn = 8'h5A;
    busRead(IO_BASE);
    rxValidIn = 1'b0;
    check("rx_emptypp_00", memDataOut, 8'h00);
    busRead(IDLE);
    check("rx_emptypp_kept", memDataOut, 8'h02);
    busRead(IO_BASE);
    check("rx_5a", memDataOut, 8'h5A);

    // RX random fill to full, then drain
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      rxValidIn = 1'b1; rxDataIn = b;
      tick();
      rxQ.push_back(b);
    end
    rxValidIn = 1'b0;
    check("rx_full_notready", rxReadyOut, 1'b0);
    rxValidIn = 1'b1; rxDataIn = 8'hEE;
    tick();
    rxValidIn = 1'b0;
    for (int i = 0; i < 16; i++) begin
      busRead(IO_BASE);
      check("rx_drain_data", memDataOut, rxQ.pop_front());
      busRead(IDLE);
      check("rx_drain_status", memDataOut, (rxQ.size() != 0) ? 8'h02 : 8'h00);
    end
    check("rx_ready_again", rxReadyOut, 1'b1);

    // Unused offsets
    busWrite(32'h0003_0002, 8'hFF);
    check("unused_wr_no_tx", txValidOut, 1'b0);
    busRead(32'h0003_0001);
    check("unused_rd_01", memDataOut, 8'h00);
`ifndef MEM_IO_PERF_EN
    busRead(32'h0003_000C);
    check("unused_rd_0c", memDataOut, 8'h00);
`endif

    // Halt and reset
    busWrite(IO_BASE, 8'h99);
    rxValidIn = 1'b1; rxDataIn = 8'h44; tick(); rxValidIn = 1'b0;
    busWrite(IDLE, 8'($urandom));
    check("halt_set", haltOut, 1'b1);
    tick(); tick();
    check("halt_sticky", haltOut, 1'b1);
    resetIn = 1'b1;
    tick();
    resetIn = 1'b0;
    check("rst2_halt", haltOut, 1'b0);
    check("rst2_txvalid", txValidOut, 1'b0);
    check("rst2_ovf", txOverflowOut, 1'b0);
    check("rst2_data", memDataOut, 8'h00);
    busRead(IDLE);
    check("rst2_status", memDataOut, 8'h00);
    busRead(IO_BASE);
    check("rst2_rx_empty", memDataOut, 8'h00);
    lastRead = 8'h00;

`ifdef MEM_IO_PERF_EN
    busWrite(32'h0003_0008, 8'h00);
    for (int i = 0; i < 5; i++) ramRead(i);
    ramWrite(32'h20, 8'hC1);
    ramWrite(32'h21, 8'hC2);
    for (int k = 0; k < 8; k++) begin
      busRead(IO_BASE + 32'h8 + 32'(k));
      expByte = 8'(64'({32'd2, 32'd5}) >> (8 * k));
      check("perf_byte", memDataOut, expByte);
    end
    busWrite(32'h0003_0008, 8'h5A);
    busRead(32'h0003_0008);
    check("perf_rd_clr", memDataOut, 8'h00);
    busRead(32'h0003_000C);
    check("perf_wr_clr", memDataOut, 8'h00);
`endif

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
